// File: rtl/sonic_pcs_st_timing_adapter_fifo.sv
// Avalon-ST timing adapter: converts upstream ready latency to downstream ready latency through a FIFO.
// Latency: a word written at edge t is at the head (out_valid possible) in cycle t+1.
// Backpressure: in_ready is advisory (leaves IN_READY_LATENCY slots for in-flight words); writes into a full FIFO without a same-cycle read are dropped and counted.
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   in_data/in_valid/in_ready upstream side; in_valid is honoured regardless of in_ready
//   out_data/out_valid/out_ready downstream side; out_ready has OUT_READY_LATENCY semantics
//   fill_level               current occupancy
//   overflow, drop_count     sticky drop flag and saturating drop counter
module sonic_pcs_st_timing_adapter_fifo #(
  parameter int DATA_WIDTH        = 2,
  parameter int DEPTH             = 8,
  parameter int IN_READY_LATENCY  = 0,
  parameter int OUT_READY_LATENCY = 0,
  parameter int DROP_CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] IRL_C   = CW'(IN_READY_LATENCY);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  rd_en;
  logic                  wr_en;
  logic                  drop;

  // Read side: with zero ready latency the sink qualifies each transfer;
  // otherwise the delayed ready grants the slot and the sink must take it.
  generate
    if (OUT_READY_LATENCY == 0) begin : g_rl0
      assign out_valid = !reset && (count != '0);
      assign rd_en     = out_valid && out_ready;
    end else begin : g_rln
      logic [OUT_READY_LATENCY-1:0] rdy_pipe;

      always_ff @(posedge clk) begin
        if (reset) begin
          rdy_pipe <= '0;
        end else begin
          rdy_pipe <= (rdy_pipe << 1) | OUT_READY_LATENCY'(out_ready);
        end
      end

      assign out_valid = !reset && rdy_pipe[OUT_READY_LATENCY-1] && (count != '0);
      assign rd_en     = out_valid;
    end
  endgenerate

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign wr_en = !reset && in_valid && ((count != DEPTH_C) || rd_en);
  assign drop  = !reset && in_valid && !wr_en;

  // Depends only on registered occupancy (and reset), never on in_valid.
  assign in_ready   = !reset && ((DEPTH_C - count) > IRL_C);
  assign out_data   = mem[rd_ptr];
  assign fill_level = count;

  // Storage is intentionally not reset; occupancy tracking makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + DROP_CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
